idft_synth: RTL and testbench



---
 rtl/idft_pkg.sv | 20 ++
 rtl/idft_synth_twiddle_rom.sv | 75 +++++++
 rtl/idft_synth.sv | 173 +++++++++++++++++
 tb/tb_idft_synth.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/idft_pkg.sv
// Shared constants, state encoding and width helpers for the inverse-DFT synthesis block.
package idft_pkg;

  // Q2.14 twiddle format: +1.0 is 16384.
  localparam int unsigned FRAC_BITS = 14;
  localparam int          ONE_Q14   = 16384;

  typedef enum logic [1:0] {
    StLoad,
    StCalc,
    StEmit
  } state_e;

  // Wide enough to sum N full-scale products without overflow.
  function automatic int unsigned acc_width(input int unsigned in_w, input int unsigned tw_w,
                                            input int unsigned log2n);
    return in_w + tw_w + log2n + 1;
  endfunction

endpackage

// File: rtl/idft_synth_twiddle_rom.sv
// Combinational cos/sin table for an N-point transform, Q2.14, rounded to nearest.
// Values come from a 64-point quarter-wave sine table, so every supported N (4..64)
// picks an exact subset of those rounded entries.
module idft_synth_twiddle_rom
  import idft_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned LOG2N = 3,
  parameter int unsigned TW_W  = 16
) (
  input  logic        [LOG2N-1:0] i_idx,
  output logic signed [TW_W-1:0]  o_cos,
  output logic signed [TW_W-1:0]  o_sin
);

  localparam int unsigned Step = 64 / N;

  logic [5:0]         w_j_sin;
  logic [5:0]         w_j_cos;
  logic signed [15:0] w_sin16;
  logic signed [15:0] w_cos16;

  // round(16384 * sin(2*pi*r/64)) for r = 0..16
  function automatic logic signed [15:0] quarter_sin(input logic [4:0] r);
    logic signed [15:0] v;
    case (r)
      5'd0:    v = 16'sd0;
      5'd1:    v = 16'sd1606;
      5'd2:    v = 16'sd3196;
      5'd3:    v = 16'sd4756;
      5'd4:    v = 16'sd6270;
      5'd5:    v = 16'sd7723;
      5'd6:    v = 16'sd9102;
      5'd7:    v = 16'sd10394;
      5'd8:    v = 16'sd11585;
      5'd9:    v = 16'sd12665;
      5'd10:   v = 16'sd13623;
      5'd11:   v = 16'sd14449;
      5'd12:   v = 16'sd15137;
      5'd13:   v = 16'sd15679;
      5'd14:   v = 16'sd16069;
      5'd15:   v = 16'sd16305;
      5'd16:   v = 16'(ONE_Q14);
      default: v = 16'sd0;
    endcase
    return v;
  endfunction

  // Full-circle sine on a 64-step angle via quadrant folding.
  function automatic logic signed [15:0] sin64(input logic [5:0] j);
    logic [4:0]         r;
    logic signed [15:0] v;
    r = {1'b0, j[3:0]};
    case (j[5:4])
      2'd0:    v = quarter_sin(r);
      2'd1:    v = quarter_sin(5'd16 - r);
      2'd2:    v = -quarter_sin(r);
      default: v = -quarter_sin(5'd16 - r);
    endcase
    return v;
  endfunction

  assign w_j_sin = 6'(i_idx) * 6'(Step);
  assign w_j_cos = w_j_sin + 6'd16;

  // Table lookup; cos is sine advanced by a quarter turn, so cos(0) is exactly ONE_Q14.
  always_comb begin
    w_sin16 = sin64(w_j_sin);
    w_cos16 = sin64(w_j_cos);
  end

  assign o_sin = TW_W'(w_sin16);
  assign o_cos = TW_W'(w_cos16);

endmodule

// File: rtl/idft_synth.sv
// Inverse DFT synthesis: loads N complex bins, then computes one real sample per N-cycle
// MAC pass and hands each out over a valid/ready port.
module idft_synth
  import idft_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned LOG2N = 3,
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 11,
  parameter int unsigned TW_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_re,
  input  logic signed [IN_W-1:0]  in_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_sample,
  output logic                    out_last,
  output logic                    busy
);

  localparam int unsigned AccW  = acc_width(IN_W, TW_W, LOG2N);
  localparam int unsigned ProdW = IN_W + TW_W;
  localparam int unsigned Shift = FRAC_BITS + LOG2N;

  localparam logic [LOG2N-1:0]       KMax      = LOG2N'(N - 1);
  localparam logic signed [AccW-1:0] RoundBias = AccW'(1) <<< (Shift - 1);
  localparam logic signed [AccW-1:0] SatMax    = AccW'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [AccW-1:0] SatMin    = AccW'(-(2 ** (OUT_W - 1)));

  // Bin storage: never reset, always fully rewritten in LOAD before use.
  logic signed [IN_W-1:0] r_bin_re [N];
  logic signed [IN_W-1:0] r_bin_im [N];

  state_e                  r_state;
  logic [LOG2N-1:0]        r_kcnt;
  logic [LOG2N-1:0]        r_n;
  logic signed [AccW-1:0]  r_acc;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic signed [OUT_W-1:0] r_out_sample;
  logic                    r_out_last;
  logic                    r_busy;

  logic                    w_in_fire;
  logic [2*LOG2N-1:0]      w_kn;
  logic [LOG2N-1:0]        w_tw_idx;
  logic signed [TW_W-1:0]  w_cos;
  logic signed [TW_W-1:0]  w_sin;
  logic signed [IN_W-1:0]  w_bin_re;
  logic signed [IN_W-1:0]  w_bin_im;
  logic signed [ProdW-1:0] w_prod_re;
  logic signed [ProdW-1:0] w_prod_im;
  logic signed [AccW-1:0]  w_term;
  logic signed [AccW-1:0]  w_sum;
  logic signed [AccW-1:0]  w_scaled;
  logic signed [OUT_W-1:0] w_sat;

  assign w_in_fire = in_valid && r_in_ready;

  // Twiddle index is (k*n) mod N, i.e. the low LOG2N bits of the product.
  assign w_kn     = (2 * LOG2N)'(r_kcnt) * (2 * LOG2N)'(r_n);
  assign w_tw_idx = w_kn[LOG2N-1:0];

  idft_synth_twiddle_rom #(
    .N     (N),
    .LOG2N (LOG2N),
    .TW_W  (TW_W)
  ) u_twiddle_rom (
    .i_idx (w_tw_idx),
    .o_cos (w_cos),
    .o_sin (w_sin)
  );

  // Capture each accepted bin at its kcnt slot.
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_bin_re[r_kcnt] <= in_re;
      r_bin_im[r_kcnt] <= in_im;
    end
  end

  // MAC term, running sum, rounding/scaling and saturation of the finished sample.
  always_comb begin
    w_bin_re  = r_bin_re[r_kcnt];
    w_bin_im  = r_bin_im[r_kcnt];
    w_prod_re = w_bin_re * w_cos;
    w_prod_im = w_bin_im * w_sin;
    w_term    = AccW'(w_prod_re) - AccW'(w_prod_im);
    w_sum     = r_acc + w_term;
    w_scaled  = (w_sum + RoundBias) >>> Shift;
    if (w_scaled > SatMax) begin
      w_sat = SatMax[OUT_W-1:0];
    end else if (w_scaled < SatMin) begin
      w_sat = SatMin[OUT_W-1:0];
    end else begin
      w_sat = w_scaled[OUT_W-1:0];
    end
  end

  // Control FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StLoad;
      r_kcnt       <= '0;
      r_n          <= '0;
      r_acc        <= '0;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_sample <= '0;
      r_out_last   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        StLoad: begin
          r_in_ready <= 1'b1;
          if (w_in_fire) begin
            if (r_kcnt == KMax) begin
              r_kcnt     <= '0;
              r_n        <= '0;
              r_acc      <= '0;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b1;
              r_state    <= StCalc;
            end else begin
              r_kcnt <= r_kcnt + 1'b1;
            end
          end
        end
        StCalc: begin
          r_acc  <= w_sum;
          r_kcnt <= r_kcnt + 1'b1;
          if (r_kcnt == KMax) begin
            r_kcnt       <= '0;
            r_out_valid  <= 1'b1;
            r_out_sample <= w_sat;
            r_out_last   <= (r_n == KMax);
            r_state      <= StEmit;
          end
        end
        StEmit: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (r_n == KMax) begin
              r_n        <= '0;
              r_busy     <= 1'b0;
              r_in_ready <= 1'b1;
              r_state    <= StLoad;
            end else begin
              r_n     <= r_n + 1'b1;
              r_acc   <= '0;
              r_state <= StCalc;
            end
          end
        end
        default: begin
          r_state <= StLoad;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_sample = r_out_sample;
  assign out_last   = r_out_last;
  assign busy       = r_busy;

endmodule

// File: tb/tb_idft_synth.sv
// Self-checking bench for idft_synth: directed frames plus randomized frames against a
// real-arithmetic reference of the inverse DFT.
module tb_idft_synth;

  localparam int N     = 8;
  localparam int LOG2N = 3;
  localparam int IN_W  = 16;
  localparam int OUT_W = 11;
  localparam int TW_W  = 16;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_re;
  logic signed [IN_W-1:0]  in_im;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_sample;
  logic                    out_last;
  logic                    busy;

  int n_pass  = 0;
  int n_total = 0;
  int fr_re   [N];
  int fr_im   [N];
  int exp_arr [N];

  always #5 clk = ~clk;

  idft_synth #(
    .N     (N),
    .LOG2N (LOG2N),
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .TW_W  (TW_W)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_re      (in_re),
    .in_im      (in_im),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sample (out_sample),
    .out_last   (out_last),
    .busy       (busy)
  );

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic longint rnd(input real x);
    if (x >= 0.0) return longint'($rtoi(x + 0.5));
    return -longint'($rtoi(-x + 0.5));
  endfunction

  // x[n] = (1/N) sum Re(X[k] e^{+j2pi kn/N}) with Q2.14 twiddles, round half up, saturate.
  function automatic int ref_sample(input int n);
    longint acc = 0;
    longint c, s, r;
    real    ang;
    for (int k = 0; k < N; k++) begin
      ang = 2.0 * 3.14159265358979323846 * real'((k * n) % N) / real'(N);
      c   = rnd(16384.0 * $cos(ang));
      s   = rnd(16384.0 * $sin(ang));
      acc += longint'(fr_re[k]) * c - longint'(fr_im[k]) * s;
    end
    r = (acc + (longint'(1) << (13 + LOG2N))) >>> (14 + LOG2N);
    if (r > 1023) r = 1023;
    if (r < -1024) r = -1024;
    return int'(r);
  endfunction

  task automatic clear_frame();
    for (int k = 0; k < N; k++) begin
      fr_re[k] = 0;
      fr_im[k] = 0;
    end
  endtask

  task automatic model_exp();
    for (int n = 0; n < N; n++) exp_arr[n] = ref_sample(n);
  endtask

  // Offer all N bins; returns at #1 after the edge that accepts the last one.
  task automatic load_frame(input bit gaps);
    bit acc_now;
    int guard;
    for (int k = 0; k < N; k++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_re    = 16'(fr_re[k]);
      in_im    = 16'(fr_im[k]);
      guard    = 0;
      do begin
        acc_now = in_ready;
        @(posedge clk);
        #1;
        guard++;
      end while (!acc_now && guard < 100);
      if (!acc_now) check_val("load_timeout", 0, 1);
    end
    in_valid = 1'b0;
  endtask

  // Collect N samples against exp_arr; optionally stall 5 cycles at sample stall_at.
  task automatic collect_frame(input string tag, input bit rand_ready, input int stall_at);
    int                      cnt;
    logic signed [OUT_W-1:0] held;
    for (int n = 0; n < N; n++) begin
      cnt = 1;
      while (!out_valid && cnt < 200) begin
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk);
        #1;
        cnt++;
      end
      check_val($sformatf("%s_lat%0d", tag, n), cnt, N + 1);
      out_ready = 1'b0;
      if (n == stall_at) begin
        held = out_sample;
        repeat (5) begin
          @(posedge clk);
          #1;
          check_val($sformatf("%s_stall_valid", tag), out_valid, 1);
          check_val($sformatf("%s_stall_sample", tag), out_sample, held);
          check_val($sformatf("%s_stall_last", tag), out_last, 0);
          check_val($sformatf("%s_stall_inrdy", tag), in_ready, 0);
        end
      end else if (rand_ready) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      check_val($sformatf("%s_sample%0d", tag, n), out_sample, exp_arr[n]);
      check_val($sformatf("%s_last%0d", tag, n), out_last, (n == N - 1) ? 1 : 0);
      check_val($sformatf("%s_inrdy%0d", tag, n), in_ready, 0);
      check_val($sformatf("%s_busy%0d", tag, n), busy, 1);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
    check_val($sformatf("%s_end_busy", tag), busy, 0);
    check_val($sformatf("%s_end_inrdy", tag), in_ready, 1);
  endtask

  task automatic set_const(input int v);
    for (int n = 0; n < N; n++) exp_arr[n] = v;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid  = 1'b0;
    in_re     = '0;
    in_im     = '0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    check_val("rst_in_ready", in_ready, 0);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_sample", out_sample, 0);
    check_val("rst_out_last", out_last, 0);
    check_val("rst_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("post_rst_in_ready", in_ready, 1);

    // DC
    clear_frame();
    fr_re[0] = 2048;
    set_const(256);
    load_frame(1'b0);
    collect_frame("dc", 1'b0, -1);

    // Cosine at bin 1
    clear_frame();
    fr_re[1] = 2048;
    fr_re[7] = 2048;
    exp_arr  = '{512, 362, 0, -362, -512, -362, 0, 362};
    load_frame(1'b0);
    collect_frame("cos", 1'b0, -1);

    // Sine via imaginary parts
    clear_frame();
    fr_im[1] = -2048;
    fr_im[7] = 2048;
    exp_arr  = '{0, 362, 512, 362, 0, -362, -512, -362};
    load_frame(1'b0);
    collect_frame("sin", 1'b0, -1);

    // Saturation both ways
    clear_frame();
    fr_re[0] = 32767;
    set_const(1023);
    load_frame(1'b0);
    collect_frame("satp", 1'b0, -1);
    clear_frame();
    fr_re[0] = -32768;
    set_const(-1024);
    load_frame(1'b0);
    collect_frame("satn", 1'b0, -1);

    // Backpressure on sample 3
    clear_frame();
    fr_re[1] = 2048;
    fr_re[7] = 2048;
    exp_arr  = '{512, 362, 0, -362, -512, -362, 0, 362};
    load_frame(1'b0);
    collect_frame("bp", 1'b0, 3);

    // Reset mid-CALC, then a clean DC frame
    clear_frame();
    for (int k = 0; k < N; k++) fr_re[k] = 1000 + k;
    load_frame(1'b0);
    repeat (3) @(posedge clk);
    #2;
    check_val("midcalc_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check_val("midcalc_out_valid", out_valid, 0);
    check_val("midcalc_busy", busy, 0);
    check_val("midcalc_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_frame();
    fr_re[0] = 2048;
    set_const(256);
    load_frame(1'b1);
    collect_frame("dc_after_rst", 1'b0, -1);

    // Randomized frames: mixed amplitude ranges, random gaps and backpressure
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < N; k++) begin
        if (f % 2 == 0) begin
          fr_re[k] = int'($urandom_range(0, 4095)) - 2048;
          fr_im[k] = int'($urandom_range(0, 4095)) - 2048;
        end else begin
          fr_re[k] = int'($urandom_range(0, 65535)) - 32768;
          fr_im[k] = int'($urandom_range(0, 65535)) - 32768;
        end
      end
      model_exp();
      load_frame(1'b1);
      collect_frame($sformatf("rand%0d", f), 1'b1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
